axi_burst_addr_gen: RTL and testbench
=====================================

// Module: axi_burst_addr_gen
// PURPOSE
//  Expands one AXI AR/AW command (addr, len, size, burst; enums from PKG_axi) into a
//  per-beat stream of address, byte-strobe, last and response status.
//  Sits downstream of the AXI slave address channel, upstream of the read/write data path.
//  Checks burst legality and flags illegal bursts per beat with SLVERR.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_BYTES  8   data bus width in bytes; power of 2, 1..128
//  LEN_W       8   AxLEN width; beats = len+1
//  ID_W        4   transaction ID width
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  cmd_valid   in   1           command valid
//  cmd_ready   out  1           command accepted when valid&ready
//  cmd_id      in   ID_W        AxID
//  cmd_addr    in   ADDR_W      AxADDR
//  cmd_len     in   LEN_W       AxLEN
//  cmd_size    in   axi_axsize_e   AxSIZE
//  cmd_burst   in   axi_axburst_e  AxBURST
//  beat_valid  out  1           beat valid
//  beat_ready  in   1           downstream takes beat
//  beat_id     out  ID_W        ID of owning command
//  beat_addr   out  ADDR_W      byte address of this beat
//  beat_strb   out  DATA_BYTES  active byte lanes of this beat
//  beat_last   out  1           final beat of burst
//  beat_resp   out  axi_rwresp_e  OKAY, or SLVERR for an illegal burst
// BEHAVIOUR
//  Reset: state IDLE, beat_valid=0, beat_addr=0, beat_strb=0, beat_last=0,
//    beat_id=0, beat_resp=OKAY, beat counter=0.
//  Reset mid-burst abandons the burst; no further beats are emitted.
//  FSM IDLE->BURST on cmd_valid&cmd_ready. BURST->IDLE on beat_valid&beat_ready&beat_last.
//  cmd_ready=1 only in IDLE. Command accepted in cycle T gives first beat_valid in T+1.
//  Back-to-back bursts have one idle bubble.
//  beat_valid=1 throughout BURST. All beat_* outputs are held stable while valid&!ready.
//  nbytes = 1<<cmd_size. aligned = addr & ~(nbytes-1). Counter n = 0..len; beat_last = (n==len).
//  Address per burst type:
//    FIXED: every beat = cmd_addr.
//    INCR: beat0 = cmd_addr (may be unaligned); beat n = aligned(cmd_addr) + n*nbytes,
//      modulo 2^ADDR_W.
//    WRAP: wsz = nbytes*(len+1); lower = cmd_addr & ~(wsz-1); next = cur+nbytes;
//      if next == lower+wsz then next = lower.
//  beat_strb: lanes [addr%DATA_BYTES .. (aligned%DATA_BYTES)+nbytes-1]. Unaligned beat0
//    drops the lower lanes.
//  Illegal burst (err latched at accept, applies to all len+1 beats):
//    burst==reserved; nbytes>DATA_BYTES; WRAP with len not in {1,3,7,15};
//    WRAP with addr not nbytes-aligned; INCR whose last byte crosses a 4KB boundary.
//  Err beats: beat_resp=SLVERR, beat_strb=0, beat_addr=cmd_addr for every beat
//    (no wrap/incr math). Beat count is unchanged so the data path stays in sync.
//  len=0: a single beat with beat_last=1 in its first cycle.
// STRUCTURE
//  PKG_axi additions:
//    function axi_size_bytes(axi_axsize_e);
//    localparam AXI_4KB = 4096;
//    struct axi_ax_cmd_t {id, addr, len, size, burst}.
//  Sub-module axi_beat_strb: combinational (addr, size) -> DATA_BYTES lane mask.
//  Address/counter/FSM stay in this module.
// TESTING
//  (DATA_BYTES=8 unless noted)
//  INCR addr=0x1004 len=3 size=4 -> addr 1004,1008,100C,1010; strb 0xF0,0x0F,0xF0,0x0F;
//    last on beat 3; OKAY.
//  INCR addr=0x1003 len=1 size=8 -> addr 1003,1008; strb 0xF8,0xFF.
//  WRAP addr=0x2038 len=3 size=8 -> 2038,2020,2028,2030; last on 2030.
//  FIXED addr=0x40 len=2 size=2 -> three beats at 0x40, strb 0x03 each.
//  Error cases (all beats SLVERR, strb=0, count preserved):
//    INCR addr=0xFF8 len=1 size=8 -> 2 beats.
//    WRAP len=2 -> 3 beats.
//    size=16 -> len+1 beats.
//  beat_ready low 3 cycles mid-burst -> outputs frozen, no beat lost or repeated.
//  cmd_ready=0 during the burst.
//  rst asserted on beat 1 of 4 -> next cycle beat_valid=0, cmd_ready=1;
//    new command then runs cleanly.

Source files
------------

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI types, constants and helpers for the burst address generator.
package axi_burst_addr_gen_pkg;

  localparam int AXI_4KB    = 4096;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_ID_W   = 4;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } axi_axsize_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_axburst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_rwresp_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } gen_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    axi_axsize_e           size;
    axi_axburst_e          burst;
  } axi_ax_cmd_t;

  function automatic int unsigned axi_size_bytes(input axi_axsize_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_beat_strb.sv
// Combinational byte-lane mask for one beat: lanes from the beat address up to
// the end of its size-aligned container on the data bus.
module axi_beat_strb
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 8
) (
  input  logic [ADDR_W-1:0]     addr,
  input  axi_axsize_e           size,
  output logic [DATA_BYTES-1:0] strb
);

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_BYTES - 1);

  logic [ADDR_W-1:0] nb;
  logic [ADDR_W-1:0] lo;
  logic [ADDR_W-1:0] hi;

  always_comb begin
    nb   = ADDR_W'(axi_size_bytes(size));
    lo   = addr & LANE_MASK;
    hi   = ((addr & ~(nb - ADDR_W'(1))) & LANE_MASK) + nb - ADDR_W'(1);
    strb = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      strb[i] = (ADDR_W'(i) >= lo) && (ADDR_W'(i) <= hi);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI address-channel command into a per-beat stream of address,
// lane strobe, last flag and response; illegal bursts yield SLVERR beats.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 8,
  parameter int LEN_W      = 8,
  parameter int ID_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  axi_axsize_e           cmd_size,
  input  axi_axburst_e          cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_W-1:0]       beat_id,
  output logic [ADDR_W-1:0]     beat_addr,
  output logic [DATA_BYTES-1:0] beat_strb,
  output logic                  beat_last,
  output axi_rwresp_e           beat_resp
);

  // Wide enough that the end-of-burst byte address never wraps.
  localparam int EW      = ADDR_W + LEN_W + 8;
  localparam int PAGE_SH = $clog2(AXI_4KB);

  gen_state_e        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  axi_axsize_e       size_q;
  axi_axburst_e      burst_q;
  logic              err_q;
  logic [ADDR_W-1:0] lower_q;
  logic [ADDR_W-1:0] upper_q;

  logic [ADDR_W-1:0] cmd_nb;
  logic [ADDR_W-1:0] cmd_wsz;
  logic [ADDR_W-1:0] cmd_lower;
  logic [EW-1:0]     last_byte;
  logic              cmd_err;

  always_comb begin
    cmd_nb    = ADDR_W'(axi_size_bytes(cmd_size));
    cmd_wsz   = cmd_nb * (ADDR_W'(cmd_len) + ADDR_W'(1));
    cmd_lower = cmd_addr & ~(cmd_wsz - ADDR_W'(1));
    last_byte = EW'(cmd_addr & ~(cmd_nb - ADDR_W'(1)))
              + EW'(cmd_nb) * (EW'(cmd_len) + EW'(1)) - EW'(1);
    cmd_err   = 1'b0;
    if (cmd_burst == BURST_RSVD) cmd_err = 1'b1;
    if (cmd_nb > ADDR_W'(DATA_BYTES)) cmd_err = 1'b1;
    if (cmd_burst == BURST_WRAP) begin
      if (!(cmd_len == LEN_W'(1) || cmd_len == LEN_W'(3) ||
            cmd_len == LEN_W'(7) || cmd_len == LEN_W'(15))) cmd_err = 1'b1;
      if ((cmd_addr & (cmd_nb - ADDR_W'(1))) != '0) cmd_err = 1'b1;
    end
    if (cmd_burst == BURST_INCR &&
        (last_byte >> PAGE_SH) != (EW'(cmd_addr) >> PAGE_SH)) cmd_err = 1'b1;
  end

  logic [ADDR_W-1:0] nb_q;
  logic [ADDR_W-1:0] wrap_inc;
  logic [ADDR_W-1:0] next_addr;

  // Error bursts keep repeating the command address.
  always_comb begin
    nb_q      = ADDR_W'(axi_size_bytes(size_q));
    wrap_inc  = beat_addr + nb_q;
    next_addr = beat_addr;
    if (!err_q) begin
      case (burst_q)
        BURST_INCR: next_addr = (beat_addr & ~(nb_q - ADDR_W'(1))) + nb_q;
        BURST_WRAP: next_addr = (wrap_inc == upper_q) ? lower_q : wrap_inc;
        default:    next_addr = beat_addr;
      endcase
    end
  end

  logic [ADDR_W-1:0]     strb_addr;
  axi_axsize_e           strb_size;
  logic [DATA_BYTES-1:0] lane_strb;

  assign strb_addr = (state == ST_IDLE) ? cmd_addr : next_addr;
  assign strb_size = (state == ST_IDLE) ? cmd_size : size_q;
  assign cmd_ready = (state == ST_IDLE);

  axi_beat_strb #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) u_strb (
    .addr (strb_addr),
    .size (strb_size),
    .strb (lane_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat_valid <= 1'b0;
      beat_id    <= '0;
      beat_addr  <= '0;
      beat_strb  <= '0;
      beat_last  <= 1'b0;
      beat_resp  <= RESP_OKAY;
      cnt        <= '0;
      len_q      <= '0;
      size_q     <= SIZE_1;
      burst_q    <= BURST_FIXED;
      err_q      <= 1'b0;
      lower_q    <= '0;
      upper_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state      <= ST_BURST;
            beat_valid <= 1'b1;
            beat_id    <= cmd_id;
            beat_addr  <= cmd_addr;
            beat_strb  <= cmd_err ? '0 : lane_strb;
            beat_last  <= (cmd_len == '0);
            beat_resp  <= cmd_err ? RESP_SLVERR : RESP_OKAY;
            cnt        <= '0;
            len_q      <= cmd_len;
            size_q     <= cmd_size;
            burst_q    <= cmd_burst;
            err_q      <= cmd_err;
            lower_q    <= cmd_lower;
            upper_q    <= cmd_lower + cmd_wsz;
          end
        end
        default: begin
          if (beat_ready) begin
            if (beat_last) begin
              state      <= ST_IDLE;
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
            end else begin
              cnt       <= cnt + LEN_W'(1);
              beat_addr <= next_addr;
              beat_strb <= err_q ? '0 : lane_strb;
              beat_last <= (cnt + LEN_W'(1) == len_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen: INCR/WRAP/FIXED beats, illegal bursts,
// backpressure, back-to-back commands and mid-burst reset.
module tb_axi_burst_addr_gen;
  import axi_burst_addr_gen_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_id;
  logic [31:0]  cmd_addr;
  logic [7:0]   cmd_len;
  axi_axsize_e  cmd_size;
  axi_axburst_e cmd_burst;
  logic         beat_valid;
  logic         beat_ready;
  logic [3:0]   beat_id;
  logic [31:0]  beat_addr;
  logic [7:0]   beat_strb;
  logic         beat_last;
  axi_rwresp_e  beat_resp;

  always #5 clk = ~clk;

  axi_burst_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_last  (beat_last),
    .beat_resp  (beat_resp)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] got_addr[$];
  logic [7:0]  got_strb[$];
  logic        got_last[$];
  logic [1:0]  got_resp[$];
  logic [3:0]  got_id[$];
  int          frozen_viol;
  int          ready_viol;
  logic        timed_out;
  logic        post_valid;
  logic        post_ready;
  logic        first_valid;

  // Callers are at a negedge; returns at the negedge after acceptance.
  task automatic issue(input axi_ax_cmd_t c);
    int w;
    cmd_valid = 1'b1;
    cmd_id    = c.id;
    cmd_addr  = c.addr;
    cmd_len   = c.len;
    cmd_size  = c.size;
    cmd_burst = c.burst;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    cmd_valid   = 1'b0;
    first_valid = beat_valid;
  endtask

  task automatic collect(input int n, input int stall_at, input int stall_len);
    int   cyc, k, stall_cnt;
    logic held, stalling;
    logic [31:0] s_addr;
    logic [7:0]  s_strb;
    logic        s_last;
    logic [1:0]  s_resp;
    got_addr.delete(); got_strb.delete(); got_last.delete();
    got_resp.delete(); got_id.delete();
    frozen_viol = 0; ready_viol = 0;
    cyc = 0; k = 0; stall_cnt = 0; held = 1'b0;
    s_addr = '0; s_strb = '0; s_last = 1'b0; s_resp = '0;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (held && (beat_addr !== s_addr || beat_strb !== s_strb ||
                   beat_last !== s_last || beat_resp !== s_resp || !beat_valid))
        frozen_viol++;
      if (beat_valid && cmd_ready) ready_viol++;
      stalling = (k == stall_at) && (stall_cnt < stall_len);
      if (stalling) stall_cnt++;
      beat_ready = !stalling;
      if (beat_valid && beat_ready) begin
        got_addr.push_back(beat_addr);
        got_strb.push_back(beat_strb);
        got_last.push_back(beat_last);
        got_resp.push_back(beat_resp);
        got_id.push_back(beat_id);
        k++;
      end
      held   = beat_valid && !beat_ready;
      s_addr = beat_addr; s_strb = beat_strb; s_last = beat_last; s_resp = beat_resp;
    end
    timed_out = (k < n);
    @(negedge clk);
    beat_ready = 1'b0;
    post_valid = beat_valid;
    post_ready = cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = SIZE_1; cmd_burst = BURST_FIXED;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h1234;
    @(negedge clk);
    total++; if (beat_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", beat_valid); bad++; end
    total++; if (beat_addr !== 32'h0) begin $display("FAIL rst_addr got=%h exp=0", beat_addr); bad++; end
    total++; if (beat_strb !== 8'h0) begin $display("FAIL rst_strb got=%h exp=0", beat_strb); bad++; end
    total++; if (beat_last !== 1'b0) begin $display("FAIL rst_last got=%b exp=0", beat_last); bad++; end
    total++; if (beat_id !== 4'h0) begin $display("FAIL rst_id got=%h exp=0", beat_id); bad++; end
    total++; if (beat_resp !== RESP_OKAY) begin $display("FAIL rst_resp got=%0d exp=0", beat_resp); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); bad++; end
    cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incr();
    axi_ax_cmd_t c;
    logic [31:0] ea[4];
    logic [7:0]  es[4];
    c  = '{id: 4'h3, addr: 32'h1004, len: 8'd3, size: SIZE_4, burst: BURST_INCR};
    ea = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    es = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
    issue(c);
    total++; if (first_valid !== 1'b1) begin $display("FAIL incr_first_valid got=%b exp=1", first_valid); bad++; end
    collect(4, -1, 0);
    total++; if (timed_out !== 1'b0) begin $display("FAIL incr_timeout got=%0d exp=4 beats", got_addr.size()); bad++; end
    for (int i = 0; i < 4; i++) begin
      total++; if (got_addr[i] !== ea[i]) begin $display("FAIL incr_addr[%0d] got=%h exp=%h", i, got_addr[i], ea[i]); bad++; end
      total++; if (got_strb[i] !== es[i]) begin $display("FAIL incr_strb[%0d] got=%h exp=%h", i, got_strb[i], es[i]); bad++; end
      total++; if (got_last[i] !== (i == 3)) begin $display("FAIL incr_last[%0d] got=%b exp=%b", i, got_last[i], i == 3); bad++; end
      total++; if (got_resp[i] !== RESP_OKAY) begin $display("FAIL incr_resp[%0d] got=%0d exp=0", i, got_resp[i]); bad++; end
      total++; if (got_id[i] !== 4'h3) begin $display("FAIL incr_id[%0d] got=%h exp=3", i, got_id[i]); bad++; end
    end
    total++; if (ready_viol !== 0) begin $display("FAIL incr_cmd_ready_busy got=%0d exp=0", ready_viol); bad++; end
    total++; if (post_valid !== 1'b0) begin $display("FAIL incr_extra_beat got=%b exp=0", post_valid); bad++; end
    total++; if (post_ready !== 1'b1) begin $display("FAIL incr_idle_ready got=%b exp=1", post_ready); bad++; end
  endtask

  task automatic test_incr_unaligned();
    axi_ax_cmd_t c;
    c = '{id: 4'h1, addr: 32'h1003, len: 8'd1, size: SIZE_8, burst: BURST_INCR};
    issue(c);
    collect(2, -1, 0);
    total++; if (got_addr[0] !== 32'h1003) begin $display("FAIL unal_addr0 got=%h exp=1003", got_addr[0]); bad++; end
    total++; if (got_addr[1] !== 32'h1008) begin $display("FAIL unal_addr1 got=%h exp=1008", got_addr[1]); bad++; end
    total++; if (got_strb[0] !== 8'hF8) begin $display("FAIL unal_strb0 got=%h exp=f8", got_strb[0]); bad++; end
    total++; if (got_strb[1] !== 8'hFF) begin $display("FAIL unal_strb1 got=%h exp=ff", got_strb[1]); bad++; end
    total++; if (got_last[1] !== 1'b1 || got_last[0] !== 1'b0) begin $display("FAIL unal_last got=%b%b exp=01", got_last[0], got_last[1]); bad++; end
  endtask

  task automatic test_wrap();
    axi_ax_cmd_t c;
    logic [31:0] ea[4];
    c  = '{id: 4'h5, addr: 32'h2038, len: 8'd3, size: SIZE_8, burst: BURST_WRAP};
    ea = '{32'h2038, 32'h2020, 32'h2028, 32'h2030};
    issue(c);
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (got_addr[i] !== ea[i]) begin $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, got_addr[i], ea[i]); bad++; end
      total++; if (got_strb[i] !== 8'hFF) begin $display("FAIL wrap_strb[%0d] got=%h exp=ff", i, got_strb[i]); bad++; end
      total++; if (got_last[i] !== (i == 3)) begin $display("FAIL wrap_last[%0d] got=%b exp=%b", i, got_last[i], i == 3); bad++; end
    end
  endtask

  task automatic test_fixed_and_single();
    axi_ax_cmd_t c;
    c = '{id: 4'h2, addr: 32'h40, len: 8'd2, size: SIZE_2, burst: BURST_FIXED};
    issue(c);
    collect(3, -1, 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (got_addr[i] !== 32'h40) begin $display("FAIL fixed_addr[%0d] got=%h exp=40", i, got_addr[i]); bad++; end
      total++; if (got_strb[i] !== 8'h03) begin $display("FAIL fixed_strb[%0d] got=%h exp=03", i, got_strb[i]); bad++; end
      total++; if (got_last[i] !== (i == 2)) begin $display("FAIL fixed_last[%0d] got=%b exp=%b", i, got_last[i], i == 2); bad++; end
    end
    c = '{id: 4'h4, addr: 32'h10, len: 8'd0, size: SIZE_4, burst: BURST_INCR};
    issue(c);
    total++; if (beat_last !== 1'b1) begin $display("FAIL single_last_first_cycle got=%b exp=1", beat_last); bad++; end
    collect(1, -1, 0);
    total++; if (got_strb[0] !== 8'h0F) begin $display("FAIL single_strb got=%h exp=0f", got_strb[0]); bad++; end
    total++; if (post_valid !== 1'b0) begin $display("FAIL single_extra_beat got=%b exp=0", post_valid); bad++; end
  endtask

  task automatic test_errors();
    axi_ax_cmd_t ec[5];
    int          nb[5];
    ec[0] = '{id: 4'h6, addr: 32'h0FF8, len: 8'd1, size: SIZE_8,  burst: BURST_INCR};
    ec[1] = '{id: 4'h7, addr: 32'h0100, len: 8'd2, size: SIZE_8,  burst: BURST_WRAP};
    ec[2] = '{id: 4'h8, addr: 32'h0200, len: 8'd1, size: SIZE_16, burst: BURST_INCR};
    ec[3] = '{id: 4'h9, addr: 32'h0300, len: 8'd0, size: SIZE_4,  burst: BURST_RSVD};
    ec[4] = '{id: 4'hA, addr: 32'h0204, len: 8'd3, size: SIZE_8,  burst: BURST_WRAP};
    nb    = '{2, 3, 2, 1, 4};
    for (int t = 0; t < 5; t++) begin
      issue(ec[t]);
      collect(nb[t], -1, 0);
      total++; if (timed_out !== 1'b0 || post_valid !== 1'b0) begin
        $display("FAIL err%0d_count got=%0d+%b exp=%0d+0", t, got_addr.size(), post_valid, nb[t]); bad++; end
      for (int i = 0; i < nb[t]; i++) begin
        total++; if (got_resp[i] !== RESP_SLVERR) begin $display("FAIL err%0d_resp[%0d] got=%0d exp=2", t, i, got_resp[i]); bad++; end
        total++; if (got_strb[i] !== 8'h00) begin $display("FAIL err%0d_strb[%0d] got=%h exp=00", t, i, got_strb[i]); bad++; end
        total++; if (got_addr[i] !== ec[t].addr) begin $display("FAIL err%0d_addr[%0d] got=%h exp=%h", t, i, got_addr[i], ec[t].addr); bad++; end
        total++; if (got_last[i] !== (i == nb[t] - 1)) begin $display("FAIL err%0d_last[%0d] got=%b exp=%b", t, i, got_last[i], i == nb[t] - 1); bad++; end
      end
    end
  endtask

  task automatic test_stall();
    axi_ax_cmd_t c;
    c = '{id: 4'hB, addr: 32'h3000, len: 8'd3, size: SIZE_8, burst: BURST_INCR};
    issue(c);
    collect(4, 1, 3);
    total++; if (frozen_viol !== 0) begin $display("FAIL stall_frozen got=%0d exp=0", frozen_viol); bad++; end
    total++; if (timed_out !== 1'b0 || post_valid !== 1'b0) begin $display("FAIL stall_count got=%0d exp=4", got_addr.size()); bad++; end
    for (int i = 0; i < 4; i++) begin
      total++; if (got_addr[i] !== 32'h3000 + 32'(i * 8)) begin
        $display("FAIL stall_addr[%0d] got=%h exp=%h", i, got_addr[i], 32'h3000 + 32'(i * 8)); bad++; end
    end
  endtask

  task automatic test_back_to_back();
    axi_ax_cmd_t a, b;
    a = '{id: 4'hC, addr: 32'h4000, len: 8'd1, size: SIZE_4, burst: BURST_INCR};
    b = '{id: 4'hD, addr: 32'h4100, len: 8'd1, size: SIZE_8, burst: BURST_INCR};
    issue(a);
    collect(2, -1, 0);
    total++; if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
      $display("FAIL b2b_bubble got=valid%b ready%b exp=valid0 ready1", post_valid, post_ready); bad++; end
    issue(b);
    total++; if (first_valid !== 1'b1) begin $display("FAIL b2b_second_first_valid got=%b exp=1", first_valid); bad++; end
    collect(2, -1, 0);
    total++; if (got_addr[0] !== 32'h4100 || got_addr[1] !== 32'h4108) begin
      $display("FAIL b2b_addr got=%h,%h exp=4100,4108", got_addr[0], got_addr[1]); bad++; end
    total++; if (got_id[1] !== 4'hD) begin $display("FAIL b2b_id got=%h exp=d", got_id[1]); bad++; end
  endtask

  task automatic test_reset_mid();
    axi_ax_cmd_t c;
    c = '{id: 4'hE, addr: 32'h5000, len: 8'd3, size: SIZE_8, burst: BURST_INCR};
    issue(c);
    beat_ready = 1'b1;
    @(negedge clk);
    total++; if (beat_addr !== 32'h5008) begin $display("FAIL rstmid_beat1 got=%h exp=5008", beat_addr); bad++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    beat_ready = 1'b0;
    total++; if (beat_valid !== 1'b0) begin $display("FAIL rstmid_valid got=%b exp=0", beat_valid); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); bad++; end
    @(negedge clk);
    total++; if (beat_valid !== 1'b0) begin $display("FAIL rstmid_no_more_beats got=%b exp=0", beat_valid); bad++; end
    c = '{id: 4'h1, addr: 32'h6000, len: 8'd1, size: SIZE_4, burst: BURST_INCR};
    issue(c);
    collect(2, -1, 0);
    total++; if (got_addr[0] !== 32'h6000 || got_addr[1] !== 32'h6004) begin
      $display("FAIL rstmid_new_addr got=%h,%h exp=6000,6004", got_addr[0], got_addr[1]); bad++; end
    total++; if (got_strb[0] !== 8'h0F || got_strb[1] !== 8'hF0) begin
      $display("FAIL rstmid_new_strb got=%h,%h exp=0f,f0", got_strb[0], got_strb[1]); bad++; end
    total++; if (got_resp[1] !== RESP_OKAY || got_last[1] !== 1'b1) begin
      $display("FAIL rstmid_new_tail got=resp%0d last%b exp=resp0 last1", got_resp[1], got_last[1]); bad++; end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_incr_unaligned();
    test_wrap();
    test_fixed_and_single();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
